fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Front-end sequencer that owns the next-PC decision for the fetch stage. It arbitrates between backend redirects (exception, mret, mispredict) and front-end predictions (RAS pop, predicted-taken branch/jal). It sequences post-redirect recovery through a small FSM, and drives the PC write enable, the fetch-valid qualifier and the RAS pointer restore. It sits between commit/CSR logic and the program counter / RAS / predictor inside fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, boot fetch address
- FLUSH_CYCLES, 2, squash cycles after a backend redirect (0..15)
- PTR_W, 4, RAS pointer width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- stall  in  1  downstream not accepting; hold PC
- pc  in  32  current fetch PC
- exception  in  1  trap request; target mtvec
- mtvec  in  32  trap vector
- mret  in  1  trap return; target mepc
- mepc  in  32  return address
- mispredicted  in  1  committed branch/jalr mispredict
- pc_update  in  32  corrected target
- flush_ptr  in  PTR_W  RAS pointer to restore on mispredict
- ras_pop  in  1  predecoded return; target ras_target
- ras_target  in  32  RAS top
- pred_taken  in  1  branch predicted taken or jal
- pred_target  in  32  predicted target
- next_pc  out  32  PC value to load
- pc_we  out  1  load next_pc at next edge
- fetch_valid  out  1  current fetched instruction is live
- ras_restore  out  1  restore RAS pointer this cycle
- ras_restore_ptr  out  PTR_W  pointer to restore
- redirect_cause  out  3  0 seq, 1 pred, 2 ras, 3 mispredict, 4 mret, 5 exception, 6 boot
- busy  out  1  state is not RUN

## Operation
- States: BOOT, RUN, REDIRECT, FLUSH. Registers: state, redir_pc (32), redir_cause (3), flush_cnt (4).
- Backend priority: exception > mret > mispredicted. A backend redirect is accepted in every state and regardless of stall. It latches the target and cause, reloads flush_cnt = FLUSH_CYCLES, and moves to REDIRECT.
- BOOT: next_pc = RESET_PC, pc_we = 1, fetch_valid = 0, cause 6. Goes to RUN, or to REDIRECT if a backend redirect is present.
- RUN without a backend redirect, front-end priority is ras_pop > pred_taken > sequential:
  - next_pc = ras_target / pred_target / pc + 4.
  - pc_we = !stall; fetch_valid = 1.
  - Front-end requests are ignored while stall = 1.
- REDIRECT: next_pc = redir_pc, pc_we = 1, fetch_valid = 0, cause = redir_cause. Goes to FLUSH if FLUSH_CYCLES > 0, else RUN.
- FLUSH: pc_we = 0, fetch_valid = 0. flush_cnt decrements every cycle, stall ignored. Goes to RUN when flush_cnt reaches 1.
- ras_restore = mispredicted in any state, combinational, even when exception or mret wins priority; ras_restore_ptr = flush_ptr, else 0.
- Arithmetic: pc + 4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. Targets pass through unmodified; misalignment is not checked here.
- busy = (state != RUN).

## Timing
- Outputs are combinational from state, registers and inputs; state updates at the rising clk edge.
- While reset is low: state = BOOT, registers cleared, pc_we forced 0, fetch_valid = 0, ras_restore = 0, next_pc = RESET_PC, redirect_cause = 6, busy = 1.
- First edge after reset deasserts: PC loads RESET_PC; RUN from the following cycle.
- Backend redirect sampled in cycle t:
  - cycle t+1: REDIRECT, pc_we = 1;
  - edge t+2: PC = target;
  - cycles t+2 .. t+1+FLUSH_CYCLES: FLUSH;
  - first valid fetch of the target in cycle t+2+FLUSH_CYCLES.
- Front-end redirect in RUN with stall = 0: PC loads the target at the next edge. Zero bubbles.
- A new backend redirect during REDIRECT or FLUSH restarts the sequence from REDIRECT with the new target.
- Reset asserted mid-sequence immediately returns to BOOT; pending redir_pc is discarded.

## Structure
- Shared package (structs.sv) holds:
  - redirect cause enum (3-bit, encodings above);
  - fetch_ctrl_state_t enum {BOOT, RUN, REDIRECT, FLUSH}.
- One combinational sub-module, fetch_target_sel: priority encoder producing target and cause from the request vector. The FSM and registers stay in fetch_redirect_ctrl.

## Test plan
- Reset release with RESET_PC = 32'h0000_1000: BOOT cycle with pc_we = 1, next_pc = 32'h1000; then RUN; with no requests, next_pc = 32'h1004.
- mispredicted = 1, pc_update = 32'h0000_0200, flush_ptr = 4'd3 with FLUSH_CYCLES = 2:
  - same cycle: ras_restore = 1, ptr = 3;
  - next cycle: REDIRECT, next_pc = 32'h200;
  - then 2 FLUSH cycles with fetch_valid = 0;
  - RUN fetch at 32'h200.
- exception, mret and mispredicted in the same cycle: target = mtvec, cause 5, ras_restore = 1.
- stall = 1 with pred_taken = 1 in RUN: pc_we = 0; exception arriving during the stall still enters REDIRECT and pc_we = 1.
- Mispredict during FLUSH: counter reloads, new target loaded, RUN delayed accordingly; pc = 32'hFFFF_FFFC sequential gives next_pc = 0.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch next-PC sequencer: redirect causes, FSM states, request vector.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package fetch_redirect_ctrl_pkg;

   typedef enum logic [2:0] {
      CAUSE_SEQ     = 3'd0,
      CAUSE_PRED    = 3'd1,
      CAUSE_RAS     = 3'd2,
      CAUSE_MISPRED = 3'd3,
      CAUSE_MRET    = 3'd4,
      CAUSE_EXC     = 3'd5,
      CAUSE_BOOT    = 3'd6
   } redirect_cause_t;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } fetch_ctrl_state_t;

   // Request vector, most urgent first.
   typedef struct packed {
      logic exception;
      logic mret;
      logic mispredicted;
      logic ras_pop;
      logic pred_taken;
   } redirect_req_t;

   function automatic logic is_backend(input redirect_req_t r);
      return r.exception | r.mret | r.mispredicted;
   endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_target_sel.sv
// Priority encoder picking the next fetch target and its cause from the request vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller masks front-end requests while stalled.
module fetch_target_sel
   import fetch_redirect_ctrl_pkg::*;
(
   input  redirect_req_t   req,
   input  logic [31:0]     pc,
   input  logic [31:0]     mtvec,
   input  logic [31:0]     mepc,
   input  logic [31:0]     pc_update,
   input  logic [31:0]     ras_target,
   input  logic [31:0]     pred_target,
   output logic [31:0]     target,
   output redirect_cause_t cause
);

   // Fixed priority: exception > mret > mispredict > ras pop > predicted taken > sequential.
   always_comb begin
      target = pc + 32'd4;
      cause  = CAUSE_SEQ;
      if (req.exception) begin
         target = mtvec;
         cause  = CAUSE_EXC;
      end else if (req.mret) begin
         target = mepc;
         cause  = CAUSE_MRET;
      end else if (req.mispredicted) begin
         target = pc_update;
         cause  = CAUSE_MISPRED;
      end else if (req.ras_pop) begin
         target = ras_target;
         cause  = CAUSE_RAS;
      end else if (req.pred_taken) begin
         target = pred_target;
         cause  = CAUSE_PRED;
      end
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencer for fetch: arbitrates backend/front-end redirects and squashes after backend redirects.
// Latency: front-end redirect zero bubbles; backend redirect fetches target valid FLUSH_CYCLES+2 cycles after request.
// Backpressure: stall holds PC in RUN only; backend redirects and flush countdown ignore stall.
module fetch_redirect_ctrl
   import fetch_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          PTR_W        = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [31:0]      pc,
   input  logic             exception,
   input  logic [31:0]      mtvec,
   input  logic             mret,
   input  logic [31:0]      mepc,
   input  logic             mispredicted,
   input  logic [31:0]      pc_update,
   input  logic [PTR_W-1:0] flush_ptr,
   input  logic             ras_pop,
   input  logic [31:0]      ras_target,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   output logic [31:0]      next_pc,
   output logic             pc_we,
   output logic             fetch_valid,
   output logic             ras_restore,
   output logic [PTR_W-1:0] ras_restore_ptr,
   output logic [2:0]       redirect_cause,
   output logic             busy
);

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

   fetch_ctrl_state_t state;
   logic [31:0]       redir_pc;
   redirect_cause_t   redir_cause;
   logic [3:0]        flush_cnt;

   redirect_req_t     req;
   logic              backend;
   logic [31:0]       sel_target;
   redirect_cause_t   sel_cause;
   redirect_cause_t   cause_out;

   // Front-end requests are dropped while stalled; backend requests always pass.
   always_comb begin
      req.exception    = exception;
      req.mret         = mret;
      req.mispredicted = mispredicted;
      req.ras_pop      = ras_pop & ~stall;
      req.pred_taken   = pred_taken & ~stall;
   end

   assign backend = is_backend(req);

   fetch_target_sel u_target_sel (
      .req         (req),
      .pc          (pc),
      .mtvec       (mtvec),
      .mepc        (mepc),
      .pc_update   (pc_update),
      .ras_target  (ras_target),
      .pred_target (pred_target),
      .target      (sel_target),
      .cause       (sel_cause)
   );

   // Sequencer: a backend redirect restarts recovery from any state; otherwise walk BOOT/REDIRECT/FLUSH back to RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BOOT;
         redir_pc    <= 32'd0;
         redir_cause <= CAUSE_SEQ;
         flush_cnt   <= 4'd0;
      end else if (backend) begin
         state       <= REDIRECT;
         redir_pc    <= sel_target;
         redir_cause <= sel_cause;
         flush_cnt   <= FLUSH_INIT;
      end else begin
         case (state)
            BOOT:     state <= RUN;
            RUN:      state <= RUN;
            REDIRECT: state <= (FLUSH_CYCLES > 0) ? FLUSH : RUN;
            FLUSH: begin
               flush_cnt <= flush_cnt - 4'd1;
               if (flush_cnt <= 4'd1) begin
                  state <= RUN;
               end
            end
            default:  state <= BOOT;
         endcase
      end
   end

   // PC load, fetch qualifier and reported cause; everything is held quiet while reset is asserted.
   always_comb begin
      next_pc     = RESET_PC;
      pc_we       = 1'b0;
      fetch_valid = 1'b0;
      cause_out   = CAUSE_BOOT;
      if (reset) begin
         case (state)
            BOOT: begin
               pc_we = 1'b1;
            end
            RUN: begin
               // The instruction fetched alongside a backend redirect is wrong-path; REDIRECT does the PC load.
               next_pc     = sel_target;
               cause_out   = sel_cause;
               pc_we       = ~backend & ~stall;
               fetch_valid = ~backend;
            end
            REDIRECT: begin
               next_pc   = redir_pc;
               cause_out = redir_cause;
               pc_we     = 1'b1;
            end
            FLUSH: begin
               next_pc   = redir_pc;
               cause_out = redir_cause;
            end
            default: ;
         endcase
      end
   end

   assign redirect_cause  = cause_out;
   assign busy            = (state != RUN);
   // Restore fires on any mispredict, even one that loses priority to a trap.
   assign ras_restore     = reset & mispredicted;
   assign ras_restore_ptr = ras_restore ? flush_ptr : '0;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed scenarios plus randomized traffic against a cycle-age reference model.
// Latency: n/a.
// Backpressure: stall is driven randomly and in directed scenarios.
module tb_fetch_redirect_ctrl;

   localparam logic [31:0] RPC = 32'h0000_1000;
   localparam int          FC  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, exception, mret, mispredicted, ras_pop, pred_taken;
   logic [31:0] pc, mtvec, mepc, pc_update, ras_target, pred_target;
   logic [3:0]  flush_ptr;
   logic [31:0] next_pc;
   logic        pc_we, fetch_valid, ras_restore, busy;
   logic [3:0]  ras_restore_ptr;
   logic [2:0]  redirect_cause;

   int total = 0;
   int bad   = 0;

   // Reference model: boot flag plus "cycles since the last accepted backend redirect".
   bit          m_boot;
   int          m_age;
   logic [31:0] m_tgt;
   logic [2:0]  m_cause;

   logic [31:0] e_next;
   logic        e_we, e_fv, e_rr, e_busy;
   logic [3:0]  e_ptr;
   logic [2:0]  e_cause;
   bit          k_pc, k_we, k_fv;

   always #5 clk = ~clk;

   fetch_redirect_ctrl #(
      .RESET_PC     (RPC),
      .FLUSH_CYCLES (FC),
      .PTR_W        (4)
   ) dut (
      .clk             (clk),
      .reset           (rst_n),
      .stall           (stall),
      .pc              (pc),
      .exception       (exception),
      .mtvec           (mtvec),
      .mret            (mret),
      .mepc            (mepc),
      .mispredicted    (mispredicted),
      .pc_update       (pc_update),
      .flush_ptr       (flush_ptr),
      .ras_pop         (ras_pop),
      .ras_target      (ras_target),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .next_pc         (next_pc),
      .pc_we           (pc_we),
      .fetch_valid     (fetch_valid),
      .ras_restore     (ras_restore),
      .ras_restore_ptr (ras_restore_ptr),
      .redirect_cause  (redirect_cause),
      .busy            (busy)
   );

   // Expected outputs for the current cycle from the model position and live inputs.
   task automatic model_eval();
      bit back;
      back  = exception | mret | mispredicted;
      e_rr  = rst_n & mispredicted;
      e_ptr = e_rr ? flush_ptr : 4'd0;
      k_pc  = 1; k_we = 1; k_fv = 1;
      if (!rst_n || m_boot) begin
         e_next = RPC; e_we = rst_n; e_fv = 0; e_cause = 3'd6; e_busy = 1;
      end else if (m_age == 1) begin
         e_next = m_tgt; e_we = 1; e_fv = 0; e_cause = m_cause; e_busy = 1;
      end else if (m_age >= 2 && m_age <= 1 + FC) begin
         k_pc = 0; e_next = 32'd0; e_cause = 3'd0; e_we = 0; e_fv = 0; e_busy = 1;
      end else begin
         e_busy = 0;
         if (back) begin
            k_pc = 0; k_we = 0; k_fv = 0;
            e_next = 32'd0; e_cause = 3'd0; e_we = 0; e_fv = 0;
         end else begin
            e_we = !stall; e_fv = 1;
            if (!stall && ras_pop) begin
               e_next = ras_target; e_cause = 3'd2;
            end else if (!stall && pred_taken) begin
               e_next = pred_target; e_cause = 3'd1;
            end else begin
               e_next = pc + 32'd4; e_cause = 3'd0;
            end
         end
      end
   endtask

   // Advance the model across one rising edge using the inputs present before it.
   task automatic model_advance();
      if (!rst_n) begin
         m_boot = 1; m_age = 0;
      end else if (exception | mret | mispredicted) begin
         m_boot  = 0; m_age = 1;
         m_tgt   = exception ? mtvec : (mret ? mepc : pc_update);
         m_cause = exception ? 3'd5 : (mret ? 3'd4 : 3'd3);
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_age >= 1) begin
         m_age = m_age + 1;
         if (m_age > 1 + FC) m_age = 0;
      end
   endtask

   task automatic tick();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; exception = 0; mret = 0; mispredicted = 0; ras_pop = 0; pred_taken = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0; mispredicted = 1; flush_ptr = 4'd5; pc = 32'h1234;
      mtvec = 0; mepc = 0; pc_update = 0; ras_target = 0; pred_target = 0;
      #3;
      total++; if (next_pc !== RPC) begin bad++; $display("FAIL rst_next_pc got %h want %h", next_pc, RPC); end
      total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL rst_pc_we got %b want 0", pc_we); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_fetch_valid got %b want 0", fetch_valid); end
      total++; if (ras_restore !== 1'b0) begin bad++; $display("FAIL rst_ras_restore got %b want 0", ras_restore); end
      total++; if (redirect_cause !== 3'd6) begin bad++; $display("FAIL rst_cause got %0d want 6", redirect_cause); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got %b want 1", busy); end
      mispredicted = 0;
      tick(); tick();
      rst_n = 1'b1;
      #3;
      total++; if (pc_we !== 1'b1 || next_pc !== RPC) begin bad++; $display("FAIL boot_load got we=%b pc=%h want we=1 pc=%h", pc_we, next_pc, RPC); end
      total++; if (fetch_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL boot_flags got fv=%b busy=%b want 0/1", fetch_valid, busy); end
      tick();
      pc = RPC;
      #3;
      total++; if (next_pc !== 32'h1004 || pc_we !== 1'b1) begin bad++; $display("FAIL run_seq got pc=%h we=%b want 00001004/1", next_pc, pc_we); end
      total++; if (fetch_valid !== 1'b1 || busy !== 1'b0 || redirect_cause !== 3'd0) begin bad++; $display("FAIL run_flags got fv=%b busy=%b cause=%0d want 1/0/0", fetch_valid, busy, redirect_cause); end
      tick();
   endtask

   task automatic test_mispredict();
      idle();
      pc = 32'h1004; mispredicted = 1; pc_update = 32'h0000_0200; flush_ptr = 4'd3;
      #3;
      total++; if (ras_restore !== 1'b1 || ras_restore_ptr !== 4'd3) begin bad++; $display("FAIL mp_restore got %b/%0d want 1/3", ras_restore, ras_restore_ptr); end
      tick();
      idle(); pc = 32'h1008;
      #3;
      total++; if (next_pc !== 32'h200 || pc_we !== 1'b1 || redirect_cause !== 3'd3) begin bad++; $display("FAIL mp_redirect got pc=%h we=%b cause=%0d want 00000200/1/3", next_pc, pc_we, redirect_cause); end
      total++; if (ras_restore !== 1'b0 || ras_restore_ptr !== 4'd0) begin bad++; $display("FAIL mp_restore_clr got %b/%0d want 0/0", ras_restore, ras_restore_ptr); end
      tick();
      for (int i = 0; i < FC; i++) begin
         #3;
         total++; if (fetch_valid !== 1'b0 || pc_we !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mp_flush%0d got fv=%b we=%b busy=%b want 0/0/1", i, fetch_valid, pc_we, busy); end
         tick();
      end
      pc = 32'h200;
      #3;
      total++; if (fetch_valid !== 1'b1 || busy !== 1'b0 || next_pc !== 32'h204) begin bad++; $display("FAIL mp_run got fv=%b busy=%b pc=%h want 1/0/00000204", fetch_valid, busy, next_pc); end
      tick();
   endtask

   task automatic test_priority();
      idle();
      exception = 1; mret = 1; mispredicted = 1; ras_pop = 1; pred_taken = 1;
      mtvec = 32'h8000_0100; mepc = 32'h0000_3000; pc_update = 32'h0000_4000; flush_ptr = 4'd9;
      #3;
      total++; if (ras_restore !== 1'b1 || ras_restore_ptr !== 4'd9) begin bad++; $display("FAIL prio_restore got %b/%0d want 1/9", ras_restore, ras_restore_ptr); end
      tick();
      idle();
      #3;
      total++; if (next_pc !== 32'h8000_0100 || redirect_cause !== 3'd5 || pc_we !== 1'b1) begin bad++; $display("FAIL prio_exc got pc=%h cause=%0d we=%b want 80000100/5/1", next_pc, redirect_cause, pc_we); end
      tick();
      mret = 1; mispredicted = 1; mepc = 32'h0000_3000; pc_update = 32'h0000_4000;
      tick();
      idle();
      #3;
      total++; if (next_pc !== 32'h3000 || redirect_cause !== 3'd4) begin bad++; $display("FAIL prio_mret got pc=%h cause=%0d want 00003000/4", next_pc, redirect_cause); end
      for (int i = 0; i <= FC; i++) tick();
   endtask

   task automatic test_stall();
      idle();
      stall = 1; pred_taken = 1; pred_target = 32'h0000_5550; pc = 32'h3000;
      #3;
      total++; if (pc_we !== 1'b0 || busy !== 1'b0 || next_pc !== 32'h3004) begin bad++; $display("FAIL stall_hold got we=%b busy=%b pc=%h want 0/0/00003004", pc_we, busy, next_pc); end
      tick();
      exception = 1; mtvec = 32'h0000_0700;
      tick();
      exception = 0;
      #3;
      total++; if (pc_we !== 1'b1 || next_pc !== 32'h700 || redirect_cause !== 3'd5 || busy !== 1'b1) begin bad++; $display("FAIL stall_exc got we=%b pc=%h cause=%0d busy=%b want 1/00000700/5/1", pc_we, next_pc, redirect_cause, busy); end
      tick(); tick(); tick();
      stall = 0; pc = 32'h700;
      #3;
      total++; if (next_pc !== 32'h5550 || redirect_cause !== 3'd1 || pc_we !== 1'b1) begin bad++; $display("FAIL pred_taken got pc=%h cause=%0d we=%b want 00005550/1/1", next_pc, redirect_cause, pc_we); end
      tick();
   endtask

   task automatic test_flush_restart();
      idle();
      exception = 1; mtvec = 32'h0000_0900;
      tick();
      idle();
      tick();
      mispredicted = 1; pc_update = 32'h0000_0A00; flush_ptr = 4'd7;
      #3;
      total++; if (fetch_valid !== 1'b0 || pc_we !== 1'b0 || ras_restore !== 1'b1) begin bad++; $display("FAIL fr_flush got fv=%b we=%b rr=%b want 0/0/1", fetch_valid, pc_we, ras_restore); end
      tick();
      idle();
      #3;
      total++; if (next_pc !== 32'hA00 || pc_we !== 1'b1 || redirect_cause !== 3'd3) begin bad++; $display("FAIL fr_redirect got pc=%h we=%b cause=%0d want 00000a00/1/3", next_pc, pc_we, redirect_cause); end
      tick();
      for (int i = 0; i < FC; i++) begin
         #3;
         total++; if (busy !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL fr_reflush%0d got busy=%b fv=%b want 1/0", i, busy, fetch_valid); end
         tick();
      end
      pc = 32'hA00;
      #3;
      total++; if (busy !== 1'b0 || next_pc !== 32'hA04) begin bad++; $display("FAIL fr_run got busy=%b pc=%h want 0/00000a04", busy, next_pc); end
      tick();
   endtask

   task automatic test_wrap();
      idle();
      pc = 32'hFFFF_FFFC;
      #3;
      total++; if (next_pc !== 32'h0 || redirect_cause !== 3'd0) begin bad++; $display("FAIL wrap got pc=%h cause=%0d want 00000000/0", next_pc, redirect_cause); end
      ras_pop = 1; pred_taken = 1; ras_target = 32'h0000_6660; pred_target = 32'h0000_7770;
      #1;
      total++; if (next_pc !== 32'h6660 || redirect_cause !== 3'd2) begin bad++; $display("FAIL ras_prio got pc=%h cause=%0d want 00006660/2", next_pc, redirect_cause); end
      tick();
      idle();
   endtask

   task automatic test_midreset();
      idle();
      exception = 1; mtvec = 32'h0000_0B00;
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b1 || pc_we !== 1'b0 || next_pc !== RPC || redirect_cause !== 3'd6) begin bad++; $display("FAIL midrst got busy=%b we=%b pc=%h cause=%0d want 1/0/%h/6", busy, pc_we, next_pc, redirect_cause, RPC); end
      tick();
      rst_n = 1'b1;
      #3;
      total++; if (pc_we !== 1'b1 || next_pc !== RPC) begin bad++; $display("FAIL midrst_boot got we=%b pc=%h want 1/%h", pc_we, next_pc, RPC); end
      tick();
      pc = RPC;
      #3;
      total++; if (busy !== 1'b0 || fetch_valid !== 1'b1 || next_pc !== RPC + 32'd4) begin bad++; $display("FAIL midrst_run got busy=%b fv=%b pc=%h want 0/1/%h", busy, fetch_valid, next_pc, RPC + 32'd4); end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         rst_n        = ($urandom_range(0, 99) != 0);
         stall        = ($urandom_range(0, 3) == 0);
         exception    = ($urandom_range(0, 39) == 0);
         mret         = ($urandom_range(0, 39) == 0);
         mispredicted = ($urandom_range(0, 19) == 0);
         ras_pop      = ($urandom_range(0, 4) == 0);
         pred_taken   = ($urandom_range(0, 2) == 0);
         pc           = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom();
         mtvec        = $urandom();
         mepc         = $urandom();
         pc_update    = $urandom();
         ras_target   = $urandom();
         pred_target  = $urandom();
         flush_ptr    = 4'($urandom_range(0, 15));
         #3;
         model_eval();
         total++; if (ras_restore !== e_rr || ras_restore_ptr !== e_ptr) begin bad++; $display("FAIL rnd%0d_restore got %b/%0d want %b/%0d", n, ras_restore, ras_restore_ptr, e_rr, e_ptr); end
         total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd%0d_busy got %b want %b", n, busy, e_busy); end
         if (k_pc) begin
            total++; if (next_pc !== e_next || redirect_cause !== e_cause) begin bad++; $display("FAIL rnd%0d_target got %h/%0d want %h/%0d", n, next_pc, redirect_cause, e_next, e_cause); end
         end
         if (k_we) begin
            total++; if (pc_we !== e_we) begin bad++; $display("FAIL rnd%0d_pc_we got %b want %b", n, pc_we, e_we); end
         end
         if (k_fv) begin
            total++; if (fetch_valid !== e_fv) begin bad++; $display("FAIL rnd%0d_fetch_valid got %b want %b", n, fetch_valid, e_fv); end
         end
         tick();
      end
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      m_boot = 1; m_age = 0; m_tgt = 32'd0; m_cause = 3'd0;
      test_reset();
      test_mispredict();
      test_priority();
      test_stall();
      test_flush_restart();
      test_wrap();
      test_midreset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
